// File: rtl/alu_exec_if.sv
// Instruction handshake plus the operand/result bus to the combinational alu.
// slave = alu_exec side; master = issue logic together with the alu instance.
interface alu_exec_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        done;
    logic        illegal;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;
    logic [15:0] alu_r15;
    logic        alu_of;

    modport master (
        output instr_valid, instr, alu_out, alu_r15, alu_of,
        input  instr_ready, done, illegal, alu_a, alu_b, alu_op
    );

    modport slave (
        input  instr_valid, instr, alu_out, alu_r15, alu_of,
        output instr_ready, done, illegal, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage controller: IDLE/READ/EXEC/WB around an external 16-bit alu.
// Optional macro ALU_EXEC_R0_ZERO_EN makes R0 a constant-zero register.
module alu_exec (
    input  logic             clk,
    input  logic             rst,
    alu_exec_if.slave        bus,
    input  logic             hw_en,
    input  logic [3:0]       hw_addr,
    input  logic [15:0]      hw_data,
    output logic             of_flag,
    input  logic [3:0]       dbg_addr,
    output logic [15:0]      dbg_data
);

`ifdef ALU_EXEC_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state_reg, state_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] alu_a_reg, alu_a_next;
    logic [15:0] alu_b_reg, alu_b_next;
    logic [2:0]  alu_op_reg, alu_op_next;
    logic [15:0] out_hold_reg, out_hold_next;
    logic [15:0] r15_hold_reg, r15_hold_next;
    logic        of_hold_reg, of_hold_next;
    logic        of_flag_reg, of_flag_next;
    logic        done_reg, done_next;
    logic        illegal_reg, illegal_next;

    logic [15:0]       rf [16];
    logic [15:0]       wr_en;
    logic [15:0][15:0] wr_data;

    logic [2:0] op;
    logic [3:0] rd, rs, rt;
    logic       unused_rsvd;
    logic       wb, hw_write;

    assign op          = instr_reg[14:12];
    assign rd          = instr_reg[11:8];
    assign rs          = instr_reg[7:4];
    assign rt          = instr_reg[3:0];
    // Bit 15 is reserved and carries no meaning.
    assign unused_rsvd = instr_reg[15];

    assign wb       = (state_reg == WB);
    assign hw_write = (state_reg == IDLE) && hw_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            instr_reg    <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            out_hold_reg <= '0;
            r15_hold_reg <= '0;
            of_hold_reg  <= 1'b0;
            of_flag_reg  <= 1'b0;
            done_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            instr_reg    <= instr_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            out_hold_reg <= out_hold_next;
            r15_hold_reg <= r15_hold_next;
            of_hold_reg  <= of_hold_next;
            of_flag_reg  <= of_flag_next;
            done_reg     <= done_next;
            illegal_reg  <= illegal_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        instr_next    = instr_reg;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        out_hold_next = out_hold_reg;
        r15_hold_next = r15_hold_reg;
        of_hold_next  = of_hold_reg;
        of_flag_next  = of_flag_reg;
        done_next     = 1'b0;
        illegal_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_next = bus.instr;
                    state_next = READ;
                end
            end
            READ: begin
                if (op == 3'b111) begin
                    done_next    = 1'b1;
                    illegal_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    alu_a_next  = rf[rs];
                    alu_b_next  = rf[rt];
                    alu_op_next = op;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                out_hold_next = bus.alu_out;
                r15_hold_next = bus.alu_r15;
                of_hold_next  = bus.alu_of;
                state_next    = WB;
            end
            WB: begin
                of_flag_next = of_hold_reg;
                done_next    = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-register write select: rd result beats the r15 side result, and the
    // host port can only win in IDLE, where WB never coincides.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_wr
            if (R0_ZERO && gi == 0) begin : g_r0
                assign wr_en[gi]   = 1'b0;
                assign wr_data[gi] = '0;
            end else begin : g_rn
                logic rd_hit;
                assign rd_hit      = wb && (rd == 4'(gi));
                assign wr_en[gi]   = rd_hit || (wb && (gi == 15)) ||
                                     (hw_write && (hw_addr == 4'(gi)));
                assign wr_data[gi] = rd_hit ? out_hold_reg :
                                     (wb ? r15_hold_reg : hw_data);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_en[i]) rf[i] <= wr_data[i];
            end
        end
    end

    assign dbg_data        = rf[dbg_addr];
    assign of_flag         = of_flag_reg;
    assign bus.instr_ready = (state_reg == IDLE);
    assign bus.done        = done_reg;
    assign bus.illegal     = illegal_reg;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_op      = alu_op_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a stand-in combinational alu (r15 = {a[7:0],b[7:0]}).
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst;
    logic        hw_en;
    logic [3:0]  hw_addr;
    logic [15:0] hw_data;
    logic        of_flag;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_exec_if bus();

    alu_exec dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hw_en    (hw_en),
        .hw_addr  (hw_addr),
        .hw_data  (hw_data),
        .of_flag  (of_flag),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    logic [15:0] sum, diff;
    assign sum  = bus.alu_a + bus.alu_b;
    assign diff = bus.alu_a - bus.alu_b;
    assign bus.alu_r15 = {bus.alu_a[7:0], bus.alu_b[7:0]};

    always_comb begin
        bus.alu_out = 16'h0000;
        bus.alu_of  = 1'b0;
        case (bus.alu_op)
            3'd0: begin
                bus.alu_out = sum;
                bus.alu_of  = (bus.alu_a[15] == bus.alu_b[15]) && (sum[15] != bus.alu_a[15]);
            end
            3'd1: begin
                bus.alu_out = diff;
                bus.alu_of  = (bus.alu_a[15] != bus.alu_b[15]) && (diff[15] != bus.alu_a[15]);
            end
            3'd2: bus.alu_out = bus.alu_a & bus.alu_b;
            3'd3: bus.alu_out = bus.alu_a | bus.alu_b;
            3'd4: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'd5: bus.alu_out = bus.alu_a << bus.alu_b[3:0];
            3'd6: bus.alu_out = bus.alu_a >> bus.alu_b[3:0];
            default: bus.alu_out = 16'h0000;
        endcase
    end

    typedef struct {
        logic        rsv;
        logic [2:0]  op;
        logic [3:0]  rd, rs, rt;
        logic [15:0] exp_rd, exp_r15;
        logic        exp_of;
    } vec_t;

    vec_t vecs [8];

`ifdef ALU_EXEC_R0_ZERO_EN
    localparam logic [15:0] R0_EXP = 16'h0000;
    localparam logic [15:0] R5_EXP = 16'h0000;
`else
    localparam logic [15:0] R0_EXP = 16'hFFFF;
    localparam logic [15:0] R5_EXP = 16'hFFFE;
`endif

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        hw_en = 1'b1; hw_addr = a; hw_data = d;
        tick;
        hw_en = 1'b0;
    endtask

    // After the accept edge, counts edges until done; -1 if it never arrives.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, output int lat);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        tick;
        bus.instr_valid = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        int lat;

        vecs[0] = '{1'b0, 3'd1, 4'd15, 4'd3, 4'd2, 16'h0F00, 16'h0F00, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 4'd8,  4'd4, 4'd5, 16'h8000, 16'hFF01, 1'b1};
        vecs[2] = '{1'b0, 3'd2, 4'd9,  4'd6, 4'd7, 16'h0000, 16'hF00F, 1'b0};
        vecs[3] = '{1'b0, 3'd3, 4'd10, 4'd6, 4'd7, 16'h0FFF, 16'hF00F, 1'b0};
        vecs[4] = '{1'b0, 3'd4, 4'd11, 4'd7, 4'd7, 16'h0000, 16'h0F0F, 1'b0};
        vecs[5] = '{1'b0, 3'd5, 4'd6,  4'd6, 4'd5, 16'h01E0, 16'hF001, 1'b0};
        vecs[6] = '{1'b0, 3'd6, 4'd12, 4'd6, 4'd5, 16'h00F0, 16'hE001, 1'b0};
        vecs[7] = '{1'b0, 3'd1, 4'd13, 4'd8, 4'd5, 16'h7FFF, 16'h0001, 1'b1};

        rst = 1'b1; hw_en = 1'b0; hw_addr = '0; hw_data = '0; dbg_addr = '0;
        bus.instr_valid = 1'b0; bus.instr = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_ready", 16'(bus.instr_ready), 16'd1);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_of", 16'(of_flag), 16'd0);
        chk("rst_op", 16'(bus.alu_op), 16'd0);
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk($sformatf("rst_r%0d", i), d, 16'h0000);
        end
        $display("reset done");

        // Add path with timing, plus host writes attempted while busy.
        host_write(4'd1, 16'h0F00);
        host_write(4'd2, 16'h0050);
        bus.instr_valid = 1'b1; bus.instr = 16'h0312;
        tick;
        bus.instr_valid = 1'b0;
        hw_en = 1'b1; hw_addr = 4'd14; hw_data = 16'h1234;
        chk("add_ready_read", 16'(bus.instr_ready), 16'd0);
        tick;
        chk("add_a", bus.alu_a, 16'h0F00);
        chk("add_b", bus.alu_b, 16'h0050);
        chk("add_ready_exec", 16'(bus.instr_ready), 16'd0);
        chk("add_done_e1", 16'(bus.done), 16'd0);
        tick;
        chk("add_ready_wb", 16'(bus.instr_ready), 16'd0);
        chk("add_done_e2", 16'(bus.done), 16'd0);
        tick;
        hw_en = 1'b0;
        chk("add_done_e3", 16'(bus.done), 16'd1);
        chk("add_ready_e3", 16'(bus.instr_ready), 16'd1);
        peek(4'd3, d);  chk("add_r3", d, 16'h0F50);
        peek(4'd15, d); chk("add_r15", d, 16'h0050);
        peek(4'd14, d); chk("busy_hw_ignored", d, 16'h0000);
        tick;
        chk("add_done_pulse", 16'(bus.done), 16'd0);
        $display("add op 0 rd 3 -> %h", 16'h0F50);

        host_write(4'd4, 16'h7FFF);
        host_write(4'd5, 16'h0001);
        host_write(4'd6, 16'h00F0);
        host_write(4'd7, 16'h0F0F);

        for (int v = 0; v < 8; v++) begin
            run_instr({vecs[v].rsv, vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].rt}, lat);
            chk($sformatf("v%0d_lat", v), 16'(lat), 16'd3);
            chk($sformatf("v%0d_illegal", v), 16'(bus.illegal), 16'd0);
            chk($sformatf("v%0d_of", v), 16'(of_flag), 16'(vecs[v].exp_of));
            peek(vecs[v].rd, d);
            chk($sformatf("v%0d_rd", v), d, vecs[v].exp_rd);
            peek(4'd15, d);
            chk($sformatf("v%0d_r15", v), d, vecs[v].exp_r15);
            $display("vec %0d op %0d rd %0d rs %0d rt %0d -> %h", v, vecs[v].op,
                     vecs[v].rd, vecs[v].rs, vecs[v].rt, vecs[v].exp_rd);
        end

        // Illegal op: 2-cycle retirement, no register or flag change.
        run_instr({1'b0, 3'b111, 4'd4, 4'd1, 4'd2}, lat);
        chk("ill_lat", 16'(lat), 16'd1);
        chk("ill_pulse", 16'(bus.illegal), 16'd1);
        chk("ill_ready", 16'(bus.instr_ready), 16'd1);
        chk("ill_of_kept", 16'(of_flag), 16'd1);
        peek(4'd4, d); chk("ill_r4", d, 16'h7FFF);
        $display("illegal op 7 rd 4");

        // Host write and accept in the same cycle; READ sees the new R1.
        hw_en = 1'b1; hw_addr = 4'd1; hw_data = 16'h1111;
        bus.instr_valid = 1'b1; bus.instr = {1'b0, 3'd0, 4'd14, 4'd1, 4'd1};
        tick;
        hw_en = 1'b0; bus.instr_valid = 1'b0;
        chk("ill_pulse_end", 16'(bus.illegal), 16'd0);
        tick;
        chk("same_a", bus.alu_a, 16'h1111);
        chk("same_b", bus.alu_b, 16'h1111);
        wait_done(lat);
        chk("same_lat", 16'(lat), 16'd2);
        peek(4'd14, d); chk("same_r14", d, 16'h2222);
        peek(4'd15, d); chk("same_r15", d, 16'h1111);
        chk("same_of", 16'(of_flag), 16'd0);
        $display("same-cycle write+accept rd 14 -> %h", 16'h2222);

        // Reset while in EXEC: nothing is written back.
        bus.instr_valid = 1'b1; bus.instr = {1'b0, 3'd0, 4'd3, 4'd1, 4'd1};
        tick;
        bus.instr_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_ready", 16'(bus.instr_ready), 16'd1);
        chk("mid_a", bus.alu_a, 16'h0000);
        chk("mid_op", 16'(bus.alu_op), 16'd0);
        tick; tick;
        chk("mid_no_done", 16'(bus.done), 16'd0);
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk($sformatf("mid_r%0d", i), d, 16'h0000);
        end
        $display("reset mid-EXEC");

        // R0 behaviour depends on the build option.
        host_write(4'd0, 16'hFFFF);
        peek(4'd0, d); chk("r0_host", d, R0_EXP);
        bus.instr_valid = 1'b1; bus.instr = {1'b0, 3'd0, 4'd5, 4'd0, 4'd0};
        tick;
        bus.instr_valid = 1'b0;
        tick;
        chk("r0_a", bus.alu_a, R0_EXP);
        chk("r0_b", bus.alu_b, R0_EXP);
        wait_done(lat);
        chk("r0_lat", 16'(lat), 16'd2);
        peek(4'd5, d); chk("r0_r5", d, R5_EXP);
        peek(4'd0, d); chk("r0_after", d, R0_EXP);
        $display("r0 op 0 rd 5 -> %h", R5_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
